// File: rtl/warships_pkg.sv
// warships_pkg: cell encoding, board geometry and controller state types
// shared by the placement controller, board_mem and draw_ships.
package warships_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, SHIP = 2'b01, HIT = 2'b10, MISS = 2'b11} cell_state_t;
    typedef enum logic [1:0] {S_CLEAR, S_PLACE, S_READY} ctl_state_t;
    localparam int GRID_SIZE = 12;
    localparam int COORD_W = 4;
    localparam int ADDR_W = 2 * COORD_W;
    localparam int CELLS = GRID_SIZE * GRID_SIZE;
endpackage

// File: rtl/ship_placement_ctl_if.sv
// ship_placement_ctl_if: synchronised mouse/clear inputs and the board_mem
// write port plus placement status; master is the controller side.
interface ship_placement_ctl_if;
    logic [11:0] mouse_x_pos;
    logic [11:0] mouse_y_pos;
    logic mouse_left;
    logic clear_req;
    logic [warships_pkg::ADDR_W-1:0] board_write_addr;
    logic [1:0] board_write_data;
    logic board_write_enable;
    logic [7:0] ship_cells;
    logic placement_done;
    modport master (
        input mouse_x_pos, mouse_y_pos, mouse_left, clear_req,
        output board_write_addr, board_write_data, board_write_enable, ship_cells, placement_done
    );
    modport slave (
        output mouse_x_pos, mouse_y_pos, mouse_left, clear_req,
        input board_write_addr, board_write_data, board_write_enable, ship_cells, placement_done
    );
endinterface

// File: rtl/grid_hit_decode.sv
// grid_hit_decode: pixel position to grid cell and button hit flags.
// All comparisons are unsigned 12-bit, so pixels left/above an edge never wrap in.
module grid_hit_decode #(
    parameter int X_POS = 100,
    parameter int Y_POS = 200,
    parameter int GRID_SIZE = 12,
    parameter int CELL_SHIFT = 5,
    parameter int BTN_X = 448,
    parameter int BTN_Y = 40,
    parameter int BTN_W = 128,
    parameter int BTN_H = 64
) (
    input logic [11:0] x,
    input logic [11:0] y,
    output logic in_grid,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic in_btn
);
    localparam logic [11:0] GX0 = 12'(X_POS);
    localparam logic [11:0] GY0 = 12'(Y_POS);
    localparam logic [11:0] GX1 = 12'(X_POS + (GRID_SIZE << CELL_SHIFT));
    localparam logic [11:0] GY1 = 12'(Y_POS + (GRID_SIZE << CELL_SHIFT));
    localparam logic [11:0] BX0 = 12'(BTN_X);
    localparam logic [11:0] BY0 = 12'(BTN_Y);
    localparam logic [11:0] BX1 = 12'(BTN_X + BTN_W);
    localparam logic [11:0] BY1 = 12'(BTN_Y + BTN_H);
    logic [11:0] dx, dy;
    assign dx = x - GX0;
    assign dy = y - GY0;
    assign cx = 4'(dx >> CELL_SHIFT);
    assign cy = 4'(dy >> CELL_SHIFT);
    assign in_grid = (x >= GX0) && (x < GX1) && (y >= GY0) && (y < GY1);
    assign in_btn = (x >= BX0) && (x < BX1) && (y >= BY0) && (y < BY1);
endmodule

// File: rtl/ship_placement_ctl.sv
// ship_placement_ctl: clears the player board, turns grid clicks into
// single-cell SHIP/EMPTY toggles and accepts START once the fleet is placed.
module ship_placement_ctl #(
    parameter int X_POS = 100,
    parameter int Y_POS = 200,
    parameter int GRID_SIZE = warships_pkg::GRID_SIZE,
    parameter int CELL_SHIFT = 5,
    parameter int BTN_X = 448,
    parameter int BTN_Y = 40,
    parameter int BTN_W = 128,
    parameter int BTN_H = 64,
    parameter int MAX_SHIP_CELLS = 20
) (
    input logic clk,
    input logic rst,
    ship_placement_ctl_if.master bus
);
    import warships_pkg::*;
    localparam logic [3:0] LAST = 4'(GRID_SIZE - 1);
    localparam logic [7:0] MAX = 8'(MAX_SHIP_CELLS);
    ctl_state_t state;
    logic left_q, click, in_grid, in_btn;
    logic [3:0] cx, cy;
    logic [7:0] sweep, idx, sweep_next;
    logic [GRID_SIZE*GRID_SIZE-1:0] shadow;
    grid_hit_decode #(
        .X_POS(X_POS), .Y_POS(Y_POS), .GRID_SIZE(GRID_SIZE), .CELL_SHIFT(CELL_SHIFT),
        .BTN_X(BTN_X), .BTN_Y(BTN_Y), .BTN_W(BTN_W), .BTN_H(BTN_H)
    ) dec (
        .x(bus.mouse_x_pos), .y(bus.mouse_y_pos),
        .in_grid(in_grid), .cx(cx), .cy(cy), .in_btn(in_btn)
    );
    assign click = bus.mouse_left & ~left_q;
    assign idx = 8'(32'(cy) * GRID_SIZE + 32'(cx));
    // sweep is kept directly in {y,x} address form, wrapping x at the grid edge
    assign sweep_next = (sweep[3:0] == LAST) ? {sweep[7:4] + 4'd1, 4'd0} : sweep + 8'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            sweep <= '0;
            left_q <= 1'b0;
            shadow <= '0;
            bus.board_write_enable <= 1'b0;
            bus.board_write_addr <= '0;
            bus.board_write_data <= EMPTY;
            bus.ship_cells <= '0;
            bus.placement_done <= 1'b0;
        end else begin
            left_q <= bus.mouse_left;
            bus.board_write_enable <= 1'b0;
            if (bus.clear_req) begin
                state <= S_CLEAR;
                sweep <= '0;
                shadow <= '0;
                bus.ship_cells <= '0;
                bus.placement_done <= 1'b0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        bus.board_write_enable <= 1'b1;
                        bus.board_write_addr <= sweep;
                        bus.board_write_data <= EMPTY;
                        sweep <= sweep_next;
                        if (sweep == {LAST, LAST}) state <= S_PLACE;
                    end
                    S_PLACE: begin
                        if (click && in_grid && shadow[idx]) begin
                            shadow[idx] <= 1'b0;
                            bus.ship_cells <= bus.ship_cells - 8'd1;
                            bus.board_write_enable <= 1'b1;
                            bus.board_write_addr <= {cy, cx};
                            bus.board_write_data <= EMPTY;
                        end else if (click && in_grid && bus.ship_cells < MAX) begin
                            shadow[idx] <= 1'b1;
                            bus.ship_cells <= bus.ship_cells + 8'd1;
                            bus.board_write_enable <= 1'b1;
                            bus.board_write_addr <= {cy, cx};
                            bus.board_write_data <= SHIP;
                        end else if (click && in_btn && bus.ship_cells == MAX) begin
                            state <= S_READY;
                            bus.placement_done <= 1'b1;
                        end
                    end
                    default: bus.placement_done <= 1'b1;
                endcase
            end
        end
    end
endmodule
